aq_cp0_rst_inv_ctrl: RTL
========================

# aq_cp0_rst_inv_ctrl

Reset-invalidation sequencer in CP0. It sits directly upstream of the IFU vector FSM, which leaves its RESET state only when this block reports completion. On the IFU's one-cycle `ifu_cp0_rst_inv_req` pulse, it walks every index of the I-cache tag array, then the D-cache tag array, then (optionally) the BHT, issuing one invalidate write per granted cycle. It then raises `cp0_ifu_rst_inv_done` as a level.

## Interface
Parameters:
- `ICACHE_IDX_W`, default 7: I-cache set-index width; 2^W sets.
- `DCACHE_IDX_W`, default 7: D-cache set-index width.
- `BHT_IDX_W`, default 8: BHT index width.

Ports:
- `forever_cpuclk`  in  1  block clock, ungated.
- `cpurst`  in  1  reset; one clock, synchronous, active-high.
- `ifu_cp0_rst_inv_req`  in  1  start pulse from the IFU vector FSM.
- `cp0_ifu_rst_inv_done`  out  1  invalidation complete (level).
- `cp0_icache_inv_vld`  out  1  I-cache invalidate request.
- `cp0_icache_inv_idx`  out  ICACHE_IDX_W  I-cache set index.
- `icache_cp0_inv_gnt`  in  1  I-cache accepts the write this cycle.
- `cp0_dcache_inv_vld`  out  1  D-cache invalidate request.
- `cp0_dcache_inv_idx`  out  DCACHE_IDX_W  D-cache set index.
- `dcache_cp0_inv_gnt`  in  1  D-cache accepts.
- `cp0_bht_inv_vld`  out  1  BHT invalidate request.
- `cp0_bht_inv_idx`  out  BHT_IDX_W  BHT index.
- `bht_cp0_inv_gnt`  in  1  BHT accepts.
- `cp0_rst_inv_busy`  out  1  high in ICACHE, DCACHE or BHT state.
- `cp0_rst_inv_st`  out  3  current state encoding, for debug.

## Operation
- State encodings: IDLE=000, ICACHE=001, DCACHE=010, BHT=011, DONE=100. Unused encodings go to IDLE.
- Transitions:
  - IDLE: `req` → ICACHE.
  - ICACHE: last transfer → DCACHE.
  - DCACHE: last transfer → BHT, or → DONE when BHT is compiled out.
  - BHT: last transfer → DONE.
  - DONE: `req` → ICACHE.
- Index counter:
  - One shared counter, width max(ICACHE_IDX_W, DCACHE_IDX_W, BHT_IDX_W).
  - Cleared to 0 on every state entry.
  - Increments on a transfer, where transfer = vld && gnt of the active memory.
  - Each `*_inv_idx` output is the counter's low bits.
- A "last transfer" is a transfer at index 2^W−1 of the active memory. The counter wraps to 0 with the state change.
- Handshake:
  - `vld` is high in that memory's state only; the other memories' `vld` outputs are 0.
  - `vld` and `idx` are held stable until `gnt`.
  - `gnt` is ignored while `vld` is low.
- `cp0_ifu_rst_inv_done` = (state==DONE).
- Start pulse handling:
  - `req` while busy is ignored; there is no restart and no queuing.
  - `req` in DONE restarts a full sequence; `done` drops the next cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from `gnt` or `req` to any output.

## Timing
- Reset values: state=IDLE, counter=0, and every output 0. This includes `cp0_rst_inv_st`=000 and all `*_idx`=0.
- `cpurst` wins over a simultaneous `req`.
- `cpurst` mid-sequence returns the block to IDLE on the next edge and aborts the walk. No partial `done` is produced.
- `req` sampled at edge N: the first `vld` is high in cycle N+1 with idx 0.
- With all grants tied high, `done` rises 2^I + 2^D + 2^B + 1 cycles after the `req` edge. For defaults that is cycle N+513.
- Each low-`gnt` cycle adds exactly one cycle of latency.
- The memory switch costs no bubble: after the I-cache last transfer, the D-cache `vld` is high the very next cycle at idx 0.

## Configuration
- `AQ_CP0_RST_INV_BHT_EN`:
  - Defined: the BHT state exists; the walk is ICACHE → DCACHE → BHT → DONE.
  - Undefined: DCACHE → DONE; `cp0_bht_inv_vld` is tied 0 and `cp0_bht_inv_idx` is tied 0. The `BHT_IDX_W` parameter and the `bht_cp0_inv_gnt` port remain, and `gnt` is ignored.

## Test plan
- Grants tied 1, defaults, macro defined:
  - `req` at edge 0 → I-cache `vld` in cycles 1–128 with idx 0–127.
  - D-cache `vld` in cycles 129–256.
  - BHT `vld` in cycles 257–512.
  - `done`=1 from cycle 513 onward; `busy`=0 at that point.
- Same stimulus, macro undefined → `done` at cycle 257; `cp0_bht_inv_vld` is never 1.
- Backpressure: `icache_cp0_inv_gnt`=0 for 5 cycles while idx=3 → idx holds 3 and `vld` stays 1 throughout; `done` lands at cycle 518.
- `req` pulse at cycle 50 during ICACHE → no effect; the counter continues and `done` still lands at 513.
- `cpurst` at cycle 200 (DCACHE) → cycle 201 has state=000, all `vld`=0 and `done`=0. A new `req` then completes normally.
- `req` in DONE → `done`=0 the next cycle and the I-cache walk restarts from idx 0. `req` and `cpurst` together → remain in IDLE.

Source files
------------

// File: rtl/aq_cp0_rst_inv_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aq_cp0_rst_inv_ctrl_if                                                   |
// | Start/done and cache/BHT invalidate handshake bundle.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface aq_cp0_rst_inv_ctrl_if #(
  parameter int ICACHE_IDX_W = 7,
  parameter int DCACHE_IDX_W = 7,
  parameter int BHT_IDX_W    = 8
);
  logic                    ifu_cp0_rst_inv_req;
  logic                    cp0_ifu_rst_inv_done;
  logic                    cp0_icache_inv_vld;
  logic [ICACHE_IDX_W-1:0] cp0_icache_inv_idx;
  logic                    icache_cp0_inv_gnt;
  logic                    cp0_dcache_inv_vld;
  logic [DCACHE_IDX_W-1:0] cp0_dcache_inv_idx;
  logic                    dcache_cp0_inv_gnt;
  logic                    cp0_bht_inv_vld;
  logic [BHT_IDX_W-1:0]    cp0_bht_inv_idx;
  logic                    bht_cp0_inv_gnt;
  logic                    cp0_rst_inv_busy;
  logic [2:0]              cp0_rst_inv_st;

  modport slave (
    input  ifu_cp0_rst_inv_req, icache_cp0_inv_gnt, dcache_cp0_inv_gnt, bht_cp0_inv_gnt,
    output cp0_ifu_rst_inv_done, cp0_icache_inv_vld, cp0_icache_inv_idx,
           cp0_dcache_inv_vld, cp0_dcache_inv_idx, cp0_bht_inv_vld, cp0_bht_inv_idx,
           cp0_rst_inv_busy, cp0_rst_inv_st
  );

  modport master (
    output ifu_cp0_rst_inv_req, icache_cp0_inv_gnt, dcache_cp0_inv_gnt, bht_cp0_inv_gnt,
    input  cp0_ifu_rst_inv_done, cp0_icache_inv_vld, cp0_icache_inv_idx,
           cp0_dcache_inv_vld, cp0_dcache_inv_idx, cp0_bht_inv_vld, cp0_bht_inv_idx,
           cp0_rst_inv_busy, cp0_rst_inv_st
  );
endinterface
`default_nettype wire

// File: rtl/aq_cp0_rst_inv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aq_cp0_rst_inv_ctrl                                                      |
// | Reset-time invalidate walk over I-cache, D-cache and optional BHT.       |
// | Optional BHT walk enabled by macro AQ_CP0_RST_INV_BHT_EN.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aq_cp0_rst_inv_ctrl #(
  parameter int ICACHE_IDX_W = 7,
  parameter int DCACHE_IDX_W = 7,
  parameter int BHT_IDX_W    = 8
) (
  input  wire logic            forever_cpuclk,
  input  wire logic            cpurst,
  aq_cp0_rst_inv_ctrl_if.slave inv_if
);
  localparam int C_ID_W = (ICACHE_IDX_W > DCACHE_IDX_W) ? ICACHE_IDX_W : DCACHE_IDX_W;
  localparam int CNT_W  = (C_ID_W > BHT_IDX_W) ? C_ID_W : BHT_IDX_W;

  localparam logic [CNT_W-1:0] C_IC_LAST = CNT_W'((64'd1 << ICACHE_IDX_W) - 64'd1);
  localparam logic [CNT_W-1:0] C_DC_LAST = CNT_W'((64'd1 << DCACHE_IDX_W) - 64'd1);
`ifdef AQ_CP0_RST_INV_BHT_EN
  localparam logic [CNT_W-1:0] C_BHT_LAST = CNT_W'((64'd1 << BHT_IDX_W) - 64'd1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ICACHE = 3'b001,
    ST_DCACHE = 3'b010,
    ST_BHT    = 3'b011,
    ST_DONE   = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ic_vld;
  logic             w_dc_vld;
  logic             w_bht_vld;
  logic             w_xfer;

  // Request strobes decode straight from state so gnt never reaches an output.
  assign w_ic_vld = (r_state == ST_ICACHE);
  assign w_dc_vld = (r_state == ST_DCACHE);
`ifdef AQ_CP0_RST_INV_BHT_EN
  assign w_bht_vld = (r_state == ST_BHT);
`else
  assign w_bht_vld = 1'b0;
`endif

  assign w_xfer = (w_ic_vld  & inv_if.icache_cp0_inv_gnt)
                | (w_dc_vld  & inv_if.dcache_cp0_inv_gnt)
                | (w_bht_vld & inv_if.bht_cp0_inv_gnt);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_nxt = inv_if.ifu_cp0_rst_inv_req ? ST_ICACHE : ST_IDLE;
      ST_ICACHE: w_state_nxt = (w_xfer && (r_cnt == C_IC_LAST)) ? ST_DCACHE : ST_ICACHE;
`ifdef AQ_CP0_RST_INV_BHT_EN
      ST_DCACHE: w_state_nxt = (w_xfer && (r_cnt == C_DC_LAST)) ? ST_BHT : ST_DCACHE;
      ST_BHT:    w_state_nxt = (w_xfer && (r_cnt == C_BHT_LAST)) ? ST_DONE : ST_BHT;
`else
      ST_DCACHE: w_state_nxt = (w_xfer && (r_cnt == C_DC_LAST)) ? ST_DONE : ST_DCACHE;
      ST_BHT:    w_state_nxt = ST_IDLE;
`endif
      ST_DONE:   w_state_nxt = inv_if.ifu_cp0_rst_inv_req ? ST_ICACHE : ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Clearing on any state change makes the next memory start at index 0 with no bubble.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign inv_if.cp0_icache_inv_vld   = w_ic_vld;
  assign inv_if.cp0_icache_inv_idx   = r_cnt[ICACHE_IDX_W-1:0];
  assign inv_if.cp0_dcache_inv_vld   = w_dc_vld;
  assign inv_if.cp0_dcache_inv_idx   = r_cnt[DCACHE_IDX_W-1:0];
  assign inv_if.cp0_bht_inv_vld      = w_bht_vld;
`ifdef AQ_CP0_RST_INV_BHT_EN
  assign inv_if.cp0_bht_inv_idx      = r_cnt[BHT_IDX_W-1:0];
`else
  assign inv_if.cp0_bht_inv_idx      = '0;
`endif
  assign inv_if.cp0_ifu_rst_inv_done = (r_state == ST_DONE);
  assign inv_if.cp0_rst_inv_busy     = (r_state == ST_ICACHE) || (r_state == ST_DCACHE)
                                     || (r_state == ST_BHT);
  assign inv_if.cp0_rst_inv_st       = r_state;
endmodule
`default_nettype wire
